// File: rtl/jump_input_seq.sv
// PS/2 scancode decoder driving walk/charge/jump controls. Every output is registered, one cycle after the code byte.
// There is no backpressure: codes are accepted every cycle that code_valid is high, and prefixes left dangling too long are dropped.
module jump_input_seq #(
    parameter int CHARGE_DIV     = 1000000,
    parameter int POWER_W        = 6,
    parameter int PREFIX_TIMEOUT = 4000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         code,
    input  logic               code_valid,
    input  logic               game_enable,
    output logic               move_left,
    output logic               move_right,
    output logic               charging,
    output logic               jump_req,
    output logic [POWER_W-1:0] jump_power,
    output logic [1:0]         jump_dir
);
    localparam int DIV_W = $clog2(CHARGE_DIV);
    localparam int TMO_W = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [POWER_W-1:0] PMAX = '1;
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t             state, state_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [POWER_W-1:0] power;
    logic               key_make, key_break, key_ext;
    logic               left_held, right_held, space_held;
    logic               left_nxt, right_nxt, space_nxt;
    logic               is_space, is_left, is_right;
    logic               start, launch, abort, charging_nxt;
    logic [1:0]         dir_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        key_make    = 1'b0;
        key_break   = 1'b0;
        key_ext     = 1'b0;
        if (code_valid) begin
            tmo_cnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (code == CODE_EXT)      state_nxt = EXT;
                    else if (code == CODE_BRK) state_nxt = BRK;
                    else                       key_make  = 1'b1;
                end
                EXT: begin
                    if (code == CODE_BRK) state_nxt = EXT_BRK;
                    else if (code != CODE_EXT) begin
                        key_make  = 1'b1;
                        key_ext   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (code == CODE_EXT) state_nxt = EXT;
                    else if (code != CODE_BRK) begin
                        key_break = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    if (code != CODE_EXT && code != CODE_BRK) begin
                        key_break = 1'b1;
                        key_ext   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            endcase
        end else if (state != IDLE) begin
            // A prefix with no follow-up byte is stale; drop it without touching the keys
            if (tmo_cnt == TMO_W'(PREFIX_TIMEOUT - 1)) begin
                state_nxt   = IDLE;
                tmo_cnt_nxt = '0;
            end else begin
                tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
        end
    end

    assign is_space = (code == 8'h29) && !key_ext;
    assign is_left  = key_ext ? (code == 8'h6B) : (code == 8'h1C);
    assign is_right = key_ext ? (code == 8'h74) : (code == 8'h23);

    always_comb begin
        left_nxt  = left_held;
        right_nxt = right_held;
        space_nxt = space_held;
        if (key_make) begin
            if (is_left)  left_nxt  = 1'b1;
            if (is_right) right_nxt = 1'b1;
            if (is_space) space_nxt = 1'b1;
        end else if (key_break) begin
            if (is_left)  left_nxt  = 1'b0;
            if (is_right) right_nxt = 1'b0;
            if (is_space) space_nxt = 1'b0;
        end
    end

    // Losing game_enable takes priority over a launch arriving in the same cycle
    assign abort        = charging && !game_enable;
    assign launch       = charging && game_enable && space_held && key_break && is_space;
    assign start        = !charging && game_enable && key_make && is_space;
    assign charging_nxt = start || (charging && !abort && !launch);
    assign dir_now      = (left_held && !right_held) ? 2'b01 :
                          (right_held && !left_held) ? 2'b10 : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_held  <= 1'b0;
            right_held <= 1'b0;
            space_held <= 1'b0;
            charging   <= 1'b0;
            div_cnt    <= '0;
            power      <= '0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            jump_req   <= 1'b0;
            jump_power <= '0;
            jump_dir   <= 2'b00;
        end else begin
            left_held  <= left_nxt;
            right_held <= right_nxt;
            space_held <= space_nxt;
            charging   <= charging_nxt;
            move_left  <= left_nxt && !right_nxt && !charging_nxt && game_enable;
            move_right <= right_nxt && !left_nxt && !charging_nxt && game_enable;
            jump_req   <= launch;
            if (start) begin
                div_cnt <= '0;
                power   <= '0;
            end else if (charging && !launch && !abort) begin
                if (div_cnt == DIV_W'(CHARGE_DIV - 1)) begin
                    div_cnt <= '0;
                    if (power != PMAX) power <= power + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
            if (launch) begin
                jump_power <= power;
                jump_dir   <= dir_now;
            end
        end
    end
endmodule

// File: tb/tb_jump_input_seq.sv
// Randomized and directed bench for jump_input_seq; two instances with different parameters share one stimulus stream.
module tb_jump_input_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] code = 8'h00;
    logic       code_valid = 1'b0;
    logic       game_enable = 1'b0;

    logic       ml_a, mr_a, ch_a, jr_a;
    logic [5:0] jp_a;
    logic [1:0] jd_a;
    logic       ml_b, mr_b, ch_b, jr_b;
    logic [2:0] jp_b;
    logic [1:0] jd_b;

    int total = 0;
    int bad = 0;
    int jr_cnt_a = 0;

    // reference model: per-instance abstract keyboard / charge state
    int div_p [2] = '{4, 2};
    int pmax_p[2] = '{63, 7};
    int tmo_p [2] = '{20, 12};
    int m_ext[2], m_brk[2], m_quiet[2];
    int m_l[2], m_r[2], m_ch[2], m_cyc[2];
    int m_ml[2], m_mr[2], m_jr[2], m_jp[2], m_jd[2];

    logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h29, 8'h6B, 8'h1C, 8'h74, 8'h23, 8'h5A};

    jump_input_seq #(.CHARGE_DIV(4), .POWER_W(6), .PREFIX_TIMEOUT(20)) dut_a (
        .clk(clk), .rst(rst), .code(code), .code_valid(code_valid), .game_enable(game_enable),
        .move_left(ml_a), .move_right(mr_a), .charging(ch_a), .jump_req(jr_a),
        .jump_power(jp_a), .jump_dir(jd_a)
    );

    jump_input_seq #(.CHARGE_DIV(2), .POWER_W(3), .PREFIX_TIMEOUT(12)) dut_b (
        .clk(clk), .rst(rst), .code(code), .code_valid(code_valid), .game_enable(game_enable),
        .move_left(ml_b), .move_right(mr_b), .charging(ch_b), .jump_req(jr_b),
        .jump_power(jp_b), .jump_dir(jd_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        int mk, br, e, sp, lf, rt, launch, abort, old_l, old_r;
        if (rst) begin
            m_ext[i] = 0; m_brk[i] = 0; m_quiet[i] = 0;
            m_l[i] = 0; m_r[i] = 0; m_ch[i] = 0; m_cyc[i] = 0;
            m_ml[i] = 0; m_mr[i] = 0; m_jr[i] = 0; m_jp[i] = 0; m_jd[i] = 0;
            return;
        end
        mk = 0; br = 0; e = 0;
        if (code_valid) begin
            m_quiet[i] = 0;
            if (code == 8'hE0) begin
                if (!(m_brk[i] != 0 && m_ext[i] != 0)) begin m_ext[i] = 1; m_brk[i] = 0; end
            end else if (code == 8'hF0) begin
                m_brk[i] = 1;
            end else begin
                e = m_ext[i];
                if (m_brk[i] != 0) br = 1; else mk = 1;
                m_ext[i] = 0; m_brk[i] = 0;
            end
        end else if (m_ext[i] != 0 || m_brk[i] != 0) begin
            m_quiet[i]++;
            if (m_quiet[i] >= tmo_p[i]) begin m_ext[i] = 0; m_brk[i] = 0; m_quiet[i] = 0; end
        end
        sp = (code == 8'h29 && e == 0);
        lf = (e != 0) ? (code == 8'h6B) : (code == 8'h1C);
        rt = (e != 0) ? (code == 8'h74) : (code == 8'h23);
        old_l = m_l[i]; old_r = m_r[i];
        abort  = (m_ch[i] != 0 && !game_enable);
        launch = (m_ch[i] != 0 && game_enable && br != 0 && sp != 0);
        m_jr[i] = launch;
        if (launch != 0) begin
            m_jp[i] = (m_cyc[i] / div_p[i] > pmax_p[i]) ? pmax_p[i] : m_cyc[i] / div_p[i];
            m_jd[i] = (old_l != 0 && old_r == 0) ? 1 : (old_r != 0 && old_l == 0) ? 2 : 0;
        end
        if (launch != 0 || abort != 0) m_ch[i] = 0;
        else if (m_ch[i] != 0) m_cyc[i]++;
        else if (mk != 0 && sp != 0 && game_enable) begin m_ch[i] = 1; m_cyc[i] = 0; end
        if (mk != 0 && lf != 0) m_l[i] = 1;
        if (mk != 0 && rt != 0) m_r[i] = 1;
        if (br != 0 && lf != 0) m_l[i] = 0;
        if (br != 0 && rt != 0) m_r[i] = 0;
        m_ml[i] = (m_l[i] != 0 && m_r[i] == 0 && m_ch[i] == 0 && game_enable) ? 1 : 0;
        m_mr[i] = (m_r[i] != 0 && m_l[i] == 0 && m_ch[i] == 0 && game_enable) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        if (jr_a) jr_cnt_a++;
        check("a.move_left",  ml_a, m_ml[0]);
        check("a.move_right", mr_a, m_mr[0]);
        check("a.charging",   ch_a, m_ch[0]);
        check("a.jump_req",   jr_a, m_jr[0]);
        check("a.jump_power", jp_a, m_jp[0]);
        check("a.jump_dir",   jd_a, m_jd[0]);
        check("b.move_left",  ml_b, m_ml[1]);
        check("b.move_right", mr_b, m_mr[1]);
        check("b.charging",   ch_b, m_ch[1]);
        check("b.jump_req",   jr_b, m_jr[1]);
        check("b.jump_power", jp_b, m_jp[1]);
        check("b.jump_dir",   jd_b, m_jd[1]);
    endtask

    task automatic send(input logic [7:0] c);
        code = c;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        code = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int dense;
        idle(2);
        check("rst.charging", ch_a, 0);
        check("rst.jump_req", jr_a, 0);
        check("rst.jump_power", jp_b, 0);
        rst = 1'b0;
        game_enable = 1'b1;
        idle(2);

        // extended left make then break
        send(8'hE0); send(8'h6B);
        check("left.make", ml_a, 1);
        send(8'hE0); send(8'hF0); send(8'h6B);
        check("left.break", ml_a, 0);

        // charge on space, 10 idle cycles, release
        jr_cnt_a = 0;
        send(8'h29); idle(10); send(8'hF0); send(8'h29);
        check("jump.req", jr_a, 1);
        check("jump.power", jp_a, 2);
        check("jump.dir", jd_a, 0);
        tick();
        check("jump.req_low", jr_a, 0);
        check("jump.pulses", jr_cnt_a, 1);

        // saturation on the narrow instance
        send(8'h29); idle(40); send(8'hF0); send(8'h29);
        check("sat.power_b", jp_b, 7);
        check("sat.power_a", jp_a, 10);

        // both directions held: no walking, vertical jump
        send(8'h1C); send(8'h23);
        check("both.left", ml_a, 0);
        check("both.right", mr_a, 0);
        send(8'h29); idle(8); send(8'hF0); send(8'h29);
        check("both.dir", jd_a, 0);
        send(8'hF0); send(8'h23);
        send(8'h29); idle(5); send(8'hF0); send(8'h29);
        check("left.dir", jd_a, 1);
        send(8'hF0); send(8'h1C);

        // stale break prefix, then exactly before the timeout
        send(8'hF0); idle(20); send(8'h29);
        check("tmo.charge_a", ch_a, 1);
        check("tmo.charge_b", ch_b, 1);
        send(8'hF0); send(8'h29);
        send(8'hF0); idle(15); send(8'h29);
        check("tmo.short_a", ch_a, 0);
        check("tmo.short_b", ch_b, 1);
        send(8'hF0); send(8'h29);

        // known launch, then abort by game_enable
        send(8'h29); idle(13); send(8'hF0); send(8'h29);
        check("pre_abort.power", jp_a, 3);
        jr_cnt_a = 0;
        send(8'h29); idle(6);
        game_enable = 1'b0;
        tick();
        check("abort.charging", ch_a, 0);
        send(8'hF0); send(8'h29);
        check("abort.req", jr_cnt_a, 0);
        check("abort.power", jp_a, 3);
        game_enable = 1'b1;
        idle(2);

        // asynchronous reset mid-charge and mid-prefix
        send(8'h29); idle(5);
        rst = 1'b1;
        #1;
        check("arst.charging", ch_a, 0);
        check("arst.power", jp_a, 0);
        tick();
        rst = 1'b0;
        jr_cnt_a = 0;
        send(8'hF0); send(8'h29); tick();
        check("arst.no_req", jr_cnt_a, 0);
        send(8'hE0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(8'h6B);
        check("arst.prefix", ml_a, 0);
        send(8'hF0); send(8'h6B);

        // randomized traffic
        dense = 1;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) dense = ~dense;
            code_valid  = dense ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
            code        = pool[$urandom_range(0, 7)];
            game_enable = ($urandom_range(0, 59) != 0);
            rst         = ($urandom_range(0, 699) == 0);
            tick();
        end
        code_valid = 1'b0;
        rst = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
